// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared defaults for the register-file writeback arbiter and the packed
// writeback request record {destination register, write data}.
// Ports: none (package only).
// -----------------------------------------------------------------------------
package regfile_pkg;

  // Default register address width (32 architectural registers).
  localparam int N_DEF     = 5;
  // Default register data width.
  localparam int WIDTH_DEF = 32;
  // Default number of writeback requesters.
  localparam int NREQ_DEF  = 3;

  // One writeback request. The field is called wreg because "reg" is a
  // reserved word in SystemVerilog.
  typedef struct packed {
    logic [N_DEF-1:0]     wreg;
    logic [WIDTH_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant logic: a pointer register plus a masked priority pick.
// The grant is combinational. It goes to the first requester at or after the
// pointer, with wrap-around. After a grant to g the pointer moves to
// (g+1) mod NREQ. Without a grant the pointer holds.
//
// Ports:
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset (forces no grant, pointer -> 0)
//   i_req  in   [NREQ-1:0] request vector
//   i_en   in   grant enable (0 suppresses every grant and freezes the pointer)
//   o_gnt  out  [NREQ-1:0] one-hot grant (all zero when nothing is granted)
// -----------------------------------------------------------------------------
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   r_ptr;
  logic [PW-1:0]   w_ptr_nxt;
  logic [NREQ-1:0] w_req;
  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_masked;
  logic [NREQ-1:0] w_gnt;

  // Isolates the lowest set bit (two's-complement trick).
  function automatic logic [NREQ-1:0] lowest_set(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

  always_comb begin
    // Reset and enable gate the requests, so every downstream term sees
    // "no request" and the pointer cannot move.
    w_req = (i_en && !rst) ? i_req : '0;

    // Keep only requesters at or after the pointer. If none of those is
    // active, fall back to the lowest active index. That fallback is the
    // wrap-around from NREQ-1 to 0.
    w_mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_mask[i] = (i >= int'(r_ptr));
    end
    w_masked = w_req & w_mask;
    w_gnt    = (|w_masked) ? lowest_set(w_masked) : lowest_set(w_req);

    w_ptr_nxt = r_ptr;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_ptr_nxt = (i == NREQ - 1) ? '0 : PW'(i + 1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (|w_gnt) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  assign o_gnt = w_gnt;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
// Arbitrates several writeback requesters onto the single write port of a
// register file. The pick is round robin. The selected write is registered
// one cycle before it reaches the register file. The pending write is also
// exposed as a forwarding source for the two read ports.
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous active-high reset
//   req_valid   in   [NREQ-1:0] requester i has a pending write
//   req_reg     in   [NREQ-1:0][N-1:0] destination register per requester
//   req_data    in   [NREQ-1:0][WIDTH-1:0] write data per requester
//   req_ready   out  [NREQ-1:0] one-hot grant; a write is consumed when
//                    valid & ready
//   hold        in   pipeline stall, no grant while high
//   wenable     out  registered register-file write enable
//   reg_in      out  [N-1:0] registered register-file write address
//   din         out  [WIDTH-1:0] registered register-file write data
//   a, b        in   [N-1:0] read addresses issued this cycle
//   fwd_a_hit   out  pending write targets a (never for r0)
//   fwd_b_hit   out  pending write targets b (never for r0)
//   fwd_a_data  out  [WIDTH-1:0] pending write data (equals din)
//   fwd_b_data  out  [WIDTH-1:0] pending write data (equals din)
// -----------------------------------------------------------------------------
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ  = NREQ_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  input  logic [NREQ-1:0][N-1:0]     req_reg,
  input  logic [NREQ-1:0][WIDTH-1:0] req_data,
  output logic [NREQ-1:0]            req_ready,
  input  logic                       hold,
  output logic                       wenable,
  output logic [N-1:0]               reg_in,
  output logic [WIDTH-1:0]           din,
  input  logic [N-1:0]               a,
  input  logic [N-1:0]               b,
  output logic                       fwd_a_hit,
  output logic                       fwd_b_hit,
  output logic [WIDTH-1:0]           fwd_a_data,
  output logic [WIDTH-1:0]           fwd_b_data
);

  logic                 w_en;
  logic [NREQ-1:0]      w_gnt;
  logic [N-1:0]         w_sel_reg;
  logic [WIDTH-1:0]     w_sel_data;

  logic                 r_wen_p1;
  logic [N-1:0]         r_reg_p1;
  logic [WIDTH-1:0]     r_din_p1;

  assign w_en = !hold;

  // The grant depends only on req_valid, hold and the pointer. It never
  // depends on a requester's own ready, so requesters can keep valid
  // independent of ready.
  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .clk   (clk),
    .rst   (rst),
    .i_req (req_valid),
    .i_en  (w_en),
    .o_gnt (w_gnt)
  );

  assign req_ready = w_gnt;

  // The grant is one-hot, so a priority-free OR-style mux is enough.
  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_reg  = req_reg[i];
        w_sel_data = req_data[i];
      end
    end
  end

  // ---- stage p0 -> p1: granted write registered toward the write port ----
  // A write to r0 is still consumed, but it never raises the enable because
  // r0 is hard-zero. Reset clears any granted-but-uncommitted write, and
  // that write is not retried.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen_p1 <= 1'b0;
      r_reg_p1 <= '0;
      r_din_p1 <= '0;
    end else if (|w_gnt) begin
      r_wen_p1 <= (w_sel_reg != '0);
      r_reg_p1 <= w_sel_reg;
      r_din_p1 <= w_sel_data;
    end else begin
      r_wen_p1 <= 1'b0;
    end
  end

  assign wenable = r_wen_p1;
  assign reg_in  = r_reg_p1;
  assign din     = r_din_p1;

  // The pending write commits at the end of this cycle. Reads issued now
  // must therefore bypass the register file. r0 never forwards.
  assign fwd_a_hit  = r_wen_p1 && (r_reg_p1 == a) && (a != '0);
  assign fwd_b_hit  = r_wen_p1 && (r_reg_p1 == b) && (b != '0);
  assign fwd_a_data = r_din_p1;
  assign fwd_b_data = r_din_p1;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0][4:0]   req_reg;
  logic [2:0][31:0]  req_data;
  logic [2:0]        req_ready;
  logic              hold;
  logic              wenable;
  logic [4:0]        reg_in;
  logic [31:0]       din;
  logic [4:0]        a;
  logic [4:0]        b;
  logic              fwd_a_hit;
  logic              fwd_b_hit;
  logic [31:0]       fwd_a_data;
  logic [31:0]       fwd_b_data;

  regfile_wb_arbiter #(.N(5), .WIDTH(32), .NREQ(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_reg    (req_reg),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .hold       (hold),
    .wenable    (wenable),
    .reg_in     (reg_in),
    .din        (din),
    .a          (a),
    .b          (b),
    .fwd_a_hit  (fwd_a_hit),
    .fwd_b_hit  (fwd_b_hit),
    .fwd_a_data (fwd_a_data),
    .fwd_b_data (fwd_b_data)
  );

  int checks = 0;
  int errors = 0;

  wb_req_t exp_q[$];
  wb_req_t mon_e;

  // Staged input values, applied at the next negedge by cyc().
  logic [2:0][4:0]  stg_reg;
  logic [2:0][31:0] stg_data;
  logic [4:0]       stg_a;
  logic [4:0]       stg_b;

  // Register-file model fed by the DUT write port. Writes are blocked while
  // reset is asserted.
  logic [31:0] rf [32];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wenable && !rst) rf[reg_in] <= din;
  end

  // Monitor: every write presented on the port must match the oldest
  // expected grant.
  always @(negedge clk) begin
    if (wenable) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got reg_in=%0d din=%h, required no write", reg_in, din);
      end else begin
        mon_e = exp_q.pop_front();
        if (reg_in !== mon_e.wreg || din !== mon_e.data) begin
          errors++;
          $display("FAIL write_port: got reg_in=%0d din=%h, required reg_in=%0d din=%h",
                   reg_in, din, mon_e.wreg, mon_e.data);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  // One clock cycle: apply inputs at negedge, check req_ready, and queue the
  // write each expected grant should produce.
  task automatic cyc(input logic r, input logic h, input logic [2:0] v,
                     input logic [2:0] exp_rdy, input string nm);
    wb_req_t e;
    @(negedge clk);
    rst = r; hold = h; req_valid = v;
    req_reg = stg_reg; req_data = stg_data; a = stg_a; b = stg_b;
    #1;
    chk({nm, "_ready"}, 64'(req_ready), 64'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i] && stg_reg[i] != 5'd0) begin
        e.wreg = stg_reg[i];
        e.data = stg_data[i];
        exp_q.push_back(e);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rst = 1'b1; hold = 1'b0; req_valid = 3'b000;
    stg_reg = '0; stg_data = '0; stg_a = 5'd0; stg_b = 5'd0;
    req_reg = '0; req_data = '0; a = 5'd0; b = 5'd0;

    // Reset: no grants, outputs cleared.
    cyc(1'b1, 1'b0, 3'b111, 3'b000, "rst0");
    cyc(1'b1, 1'b0, 3'b111, 3'b000, "rst1");
    chk("rst_wenable", 64'(wenable), 64'd0);
    chk("rst_reg_in",  64'(reg_in),  64'd0);
    chk("rst_din",     64'(din),     64'd0);

    // Round robin from pointer 0 with all requesters valid.
    stg_reg[0] = 5'd1; stg_data[0] = 32'h11;
    stg_reg[1] = 5'd2; stg_data[1] = 32'h22;
    stg_reg[2] = 5'd3; stg_data[2] = 32'h33;
    stg_a = 5'd1; stg_b = 5'd2;
    cyc(1'b0, 1'b0, 3'b111, 3'b001, "rr0");
    chk("post_rst_fwd_a", 64'(fwd_a_hit), 64'd0);
    chk("post_rst_fwd_b", 64'(fwd_b_hit), 64'd0);
    cyc(1'b0, 1'b0, 3'b111, 3'b010, "rr1");
    cyc(1'b0, 1'b0, 3'b111, 3'b100, "rr2");
    cyc(1'b0, 1'b0, 3'b111, 3'b001, "rr3");

    // Pointer is 1: requester 0 only is reached by wrap-around.
    stg_reg[0] = 5'd15; stg_data[0] = 32'd2047;
    cyc(1'b0, 1'b0, 3'b001, 3'b001, "wrap0");
    stg_a = 5'd15; stg_b = 5'd0;
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "idle1");
    chk("w15_wenable",   64'(wenable),    64'd1);
    chk("w15_reg_in",    64'(reg_in),     64'd15);
    chk("w15_din",       64'(din),        64'd2047);
    chk("w15_fwd_a_hit", 64'(fwd_a_hit),  64'd1);
    chk("w15_fwd_a_dat", 64'(fwd_a_data), 64'd2047);
    chk("w15_fwd_b_r0",  64'(fwd_b_hit),  64'd0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "idle2");
    chk("rf15",          64'(rf[15]),     64'd2047);
    chk("rf1",           64'(rf[1]),      64'h11);
    chk("rf2",           64'(rf[2]),      64'h22);
    chk("rf3",           64'(rf[3]),      64'h33);
    chk("idle_fwd_a",    64'(fwd_a_hit),  64'd0);

    // Write to r0: accepted but no enable.
    stg_reg[1] = 5'd0; stg_data[1] = 32'd5;
    cyc(1'b0, 1'b0, 3'b010, 3'b010, "r0_grant");
    stg_a = 5'd0;
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "r0_after");
    chk("r0_wenable", 64'(wenable),   64'd0);
    chk("r0_fwd_a",   64'(fwd_a_hit), 64'd0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "r0_idle");
    chk("rf0", 64'(rf[0]), 64'd0);

    // Hold with pointer at 2.
    cyc(1'b0, 1'b1, 3'b111, 3'b000, "hold0");
    cyc(1'b0, 1'b1, 3'b111, 3'b000, "hold1");
    chk("hold1_wen", 64'(wenable), 64'd0);
    cyc(1'b0, 1'b1, 3'b111, 3'b000, "hold2");
    chk("hold2_wen", 64'(wenable), 64'd0);
    cyc(1'b0, 1'b0, 3'b111, 3'b100, "hold_rel");
    chk("hold_rel_wen", 64'(wenable), 64'd0);

    // Forwarding of reg 7 = 0xDEAD, pointer at 0.
    stg_reg[0] = 5'd7; stg_data[0] = 32'hDEAD;
    cyc(1'b0, 1'b0, 3'b001, 3'b001, "g7");
    stg_a = 5'd7; stg_b = 5'd8;
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "fwd7");
    chk("fwd7_a_hit",  64'(fwd_a_hit),  64'd1);
    chk("fwd7_a_data", 64'(fwd_a_data), 64'hDEAD);
    chk("fwd7_b_hit",  64'(fwd_b_hit),  64'd0);
    chk("fwd7_b_data", 64'(fwd_b_data), 64'hDEAD);

    // Back-to-back writes to the same register: the later one wins.
    stg_reg[1] = 5'd9; stg_data[1] = 32'd1;
    stg_reg[2] = 5'd9; stg_data[2] = 32'd2;
    cyc(1'b0, 1'b0, 3'b010, 3'b010, "same_a");
    cyc(1'b0, 1'b0, 3'b100, 3'b100, "same_b");
    stg_a = 5'd9;
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "same_idle1");
    chk("same_fwd_hit",  64'(fwd_a_hit),  64'd1);
    chk("same_fwd_data", 64'(fwd_a_data), 64'd2);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "same_idle2");
    chk("rf9", 64'(rf[9]), 64'd2);

    // Reset right after a grant: the write is dropped, pointer back to 0.
    stg_reg[1] = 5'd20; stg_data[1] = 32'hBEEF;
    cyc(1'b0, 1'b0, 3'b010, 3'b010, "pre_rst");
    cyc(1'b1, 1'b0, 3'b111, 3'b000, "rst_mid");
    stg_a = 5'd20;
    cyc(1'b0, 1'b0, 3'b111, 3'b001, "post_rst");
    chk("post_rst_wen",   64'(wenable),   64'd0);
    chk("post_rst_fwd20", 64'(fwd_a_hit), 64'd0);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "drain0");
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "drain1");
    chk("rf20_dropped", 64'(rf[20]), 64'd0);
    chk("rf7",          64'(rf[7]),  64'hDEAD);
    cyc(1'b0, 1'b0, 3'b000, 3'b000, "drain2");
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter N, default 5, register address width.
REQ-002 Parameter WIDTH, default 32, data width.
REQ-003 Parameter NREQ, default 3, number of writeback requesters.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_valid  input  [NREQ-1:0]  requester i has a pending write.
REQ-007 req_reg  input  [NREQ-1:0][N-1:0]  destination register per requester.
REQ-008 req_data  input  [NREQ-1:0][WIDTH-1:0]  write data per requester.
REQ-009 req_ready  output  [NREQ-1:0]  one-hot grant; the write is consumed in a cycle where valid and ready are both 1.
REQ-010 hold  input  1  pipeline stall; while 1, no grant is issued.
REQ-011 wenable  output  1  register-file write enable, registered.
REQ-012 reg_in  output  N  register-file write address, registered.
REQ-013 din  output  WIDTH  register-file write data, registered.
REQ-014 a, b  input  N  register-file read addresses being issued this cycle.
REQ-015 fwd_a_hit, fwd_b_hit  output  1  the pending write targets a / b.
REQ-016 fwd_a_data, fwd_b_data  output  WIDTH  the pending write data, equal to din.

Function
REQ-017 req_ready SHALL be combinational from req_valid, hold and the round-robin pointer; at most one bit SHALL be 1.
REQ-018 Grant selection SHALL choose the first valid requester at or after the pointer, in index order with wrap-around from NREQ-1 to 0.
REQ-019 After a grant to requester g, the pointer SHALL become (g+1) mod NREQ on the next edge; with no grant, the pointer SHALL hold.
REQ-020 The pointer SHALL NOT advance when hold=1, and it SHALL NOT advance when no requester is valid.
REQ-021 A requester's valid SHALL NOT depend on its ready.
REQ-022 Writes SHALL have a latency of one cycle: a grant in cycle t drives wenable/reg_in/din in cycle t+1, and the register file commits at the end of t+1.
REQ-023 A cycle with no grant SHALL drive wenable=0 in the next cycle; reg_in and din SHALL hold their previous values.
REQ-024 A granted write to register 0 SHALL be accepted (ready=1) and SHALL produce wenable=0, because r0 is hard-zero.
REQ-025 fwd_a_hit SHALL equal wenable && (reg_in==a) && (a!=0); fwd_b_hit is the same with b.
REQ-026 fwd_x_data SHALL equal din regardless of the hit flag.
REQ-027 Requests presented on the same cycle as a pending write to the same register SHALL be legal; later writes win by commit order.

Reset
REQ-028 While rst=1: req_ready=0, and on the next edge wenable=0, reg_in=0, din=0 and the pointer becomes 0.
REQ-029 Forwarding outputs SHALL read 0 hits during the cycle after reset.
REQ-030 Reset mid-operation SHALL drop any granted-but-uncommitted write; the dropped write is not retried.

Structure
REQ-031 Package regfile_pkg SHALL hold the N/WIDTH/NREQ defaults and the typedef wb_req_t {reg, data}.
REQ-032 The round-robin grant logic (pointer register plus masked priority pick) SHALL be a sub-module rr_arbiter, parameterised by NREQ.
REQ-033 All outputs except req_ready and the fwd_* outputs SHALL be direct register outputs.

Verification
REQ-034 After reset, req_valid=001, req_reg[0]=15, req_data[0]=2047 -> req_ready=001 that cycle; next cycle wenable=1, reg_in=15, din=2047; register file a=15 returns 2047 one cycle later.
REQ-035 req_valid=111 held for 4 cycles after reset -> req_ready sequence is 001, 010, 100, 001.
REQ-036 req_valid=010, req_reg[1]=0, req_data[1]=5 -> req_ready=010; next cycle wenable=0; register file r0 still reads 0.
REQ-037 hold=1 with req_valid=111 for 3 cycles -> req_ready=000 and wenable=0 throughout, pointer unchanged; hold=0 -> grant to the pointer index.
REQ-038 Grant reg 7 with data 0xDEAD, then a=7, b=8 -> fwd_a_hit=1, fwd_a_data=0xDEAD, fwd_b_hit=0.
REQ-039 Grant in cycle t, rst=1 in cycle t+1 -> wenable=0 after the edge, no register-file change, pointer=0.
